// File: rtl/mario_vram_ctl.sv
// CPU-to-VRAM access sequencer: latch, wait for VRAM to be free, strobe, acknowledge (4-phase REQ/ACK).
// Latency: ack 4 I_CEN ticks after the request when VRAM is free. CPU is held via O_CPU_WAITn while the VRAM is busy.
module mario_vram_ctl #(
  parameter int STROBE_LEN = 2,
  parameter int MAX_WAIT   = 255
) (
  input  logic       I_CLK_48M,
  input  logic       I_RESET,
  input  logic       I_CEN,
  input  logic       I_CPU_REQ,
  input  logic       I_CPU_WE,
  input  logic [9:0] I_CPU_AB,
  input  logic [7:0] I_CPU_DB,
  output logic [7:0] O_CPU_DB,
  output logic       O_CPU_WAITn,
  output logic       O_CPU_ACK,
  output logic [9:0] O_AB,
  output logic [7:0] O_DB,
  output logic       O_VRAM_WRn,
  output logic       O_VRAM_RDn,
  input  logic [7:0] I_DB,
  input  logic       I_VRAMBUSYn,
  output logic       O_TIMEOUT
);

  typedef enum logic [2:0] {IDLE, LATCH, WAITBUSY, STROBE, ACK} state_t;

  localparam logic [3:0] STRB_LOAD = 4'(STROBE_LEN);
  localparam logic [7:0] WAIT_LIM  = 8'(MAX_WAIT);

  state_t     state, state_nxt;
  logic       we_q;
  logic [9:0] ab_q;
  logic [7:0] db_q;
  logic [7:0] rd_q;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic [3:0] strb_cnt;
  logic       strb_last;
  logic       timeout_q;

  assign wait_inc  = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
  assign strb_last = (strb_cnt <= 4'd1);

  always_comb begin
    state_nxt = state;
    if (I_CEN) begin
      case (state)
        IDLE:     if (I_CPU_REQ) state_nxt = LATCH;
        LATCH:    state_nxt = WAITBUSY;
        WAITBUSY: if (I_VRAMBUSYn) state_nxt = STROBE;
        // Losing the bus mid-strobe restarts the access; this takes priority over completion.
        STROBE: begin
          if (!I_VRAMBUSYn)   state_nxt = WAITBUSY;
          else if (strb_last) state_nxt = ACK;
        end
        ACK:      if (!I_CPU_REQ) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge I_CLK_48M) begin
    if (I_RESET) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      ab_q      <= 10'h000;
      db_q      <= 8'h00;
      rd_q      <= 8'h00;
      wait_cnt  <= 8'h00;
      strb_cnt  <= 4'h0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (I_CEN) begin
        case (state)
          IDLE: begin
            if (I_CPU_REQ) begin
              we_q <= I_CPU_WE;
              ab_q <= I_CPU_AB;
              db_q <= I_CPU_DB;
            end
          end
          LATCH: wait_cnt <= 8'h00;
          WAITBUSY: begin
            if (I_VRAMBUSYn) begin
              strb_cnt <= STRB_LOAD;
            end else begin
              wait_cnt <= wait_inc;
              if (wait_inc >= WAIT_LIM) timeout_q <= 1'b1;
            end
          end
          STROBE: begin
            if (I_VRAMBUSYn) begin
              strb_cnt <= strb_cnt - 4'd1;
              if (strb_last && !we_q) rd_q <= I_DB;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Every bus output decodes from registered state, so strobes change exactly on the transition edge.
  assign O_CPU_WAITn = !((state == LATCH) || (state == WAITBUSY) || (state == STROBE));
  assign O_CPU_ACK   = (state == ACK);
  assign O_AB        = (state == IDLE) ? 10'h000 : ab_q;
  assign O_VRAM_WRn  = !((state == STROBE) && we_q);
  assign O_VRAM_RDn  = !((state == STROBE) && !we_q);
  assign O_DB        = ((state == STROBE) && we_q) ? db_q : 8'h00;
  assign O_CPU_DB    = rd_q;
  assign O_TIMEOUT   = timeout_q;

endmodule
